// File: rtl/mem_noc_router_1ton_pkg.sv
// Shared request/response types and default address map for the 1-to-N memory NoC router.
package mem_noc_router_1ton_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } mem_resp_t;

   // Slot 0 = CLINT, 1 = PLIC, 2 = mem_noc, 3 = upper memory window.
   localparam logic [4*32-1:0] NOC_SLV_BASE =
      {32'h3000_0000, 32'h2000_0000, 32'h0C00_0000, 32'h0200_0000};
   localparam logic [4*32-1:0] NOC_SLV_MASK =
      {32'hF000_0000, 32'hF000_0000, 32'hFC00_0000, 32'hFFFF_0000};
   localparam logic [31:0]     NOC_DERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_noc_router_1ton_addr_dec.sv
// Priority address decoder: lowest matching window wins, no match yields index N_SLV.
module mem_noc_addr_dec #(
   parameter int                    N_SLV    = 4,
   parameter int                    TW       = $clog2(N_SLV+1),
   parameter logic [N_SLV*32-1:0]   SLV_BASE = '0,
   parameter logic [N_SLV*32-1:0]   SLV_MASK = '0
) (
   input  logic [31:0]   addr,
   output logic [TW-1:0] tgt,
   output logic          hit
);

   always_comb begin
      tgt = TW'(N_SLV);
      hit = 1'b0;
      // Walk downwards so the lowest matching index is the last assignment.
      for (int i = N_SLV-1; i >= 0; i--) begin
         if ((addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            tgt = TW'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_noc_router_1ton.sv
// 1-to-N memory NoC router with in-order outstanding tracking and an internal decode-error responder.
module mem_noc_router_1ton
   import mem_noc_router_1ton_pkg::*;
#(
   parameter int                  N_SLV      = 4,
   parameter int                  MAX_OSTD   = 4,
   parameter logic [N_SLV*32-1:0] SLV_BASE   = NOC_SLV_BASE,
   parameter logic [N_SLV*32-1:0] SLV_MASK   = NOC_SLV_MASK,
   parameter logic [31:0]         DERR_RDATA = NOC_DERR_RDATA
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  mn_req_valid,
   output logic                  mn_req_ready,
   input  mem_req_t              mn_req,
   output logic                  mn_resp_valid,
   input  logic                  mn_resp_ready,
   output mem_resp_t             mn_resp,
   output logic [N_SLV-1:0]      sn_req_valid,
   input  logic [N_SLV-1:0]      sn_req_ready,
   output mem_req_t [N_SLV-1:0]  sn_req,
   input  logic [N_SLV-1:0]      sn_resp_valid,
   output logic [N_SLV-1:0]      sn_resp_ready,
   input  mem_resp_t [N_SLV-1:0] sn_resp,
   output logic                  derr_pulse
);

   localparam int TW = $clog2(N_SLV+1);
   localparam int CW = $clog2(MAX_OSTD+1);

   logic [CW-1:0] cnt;
   logic [TW-1:0] cur_tgt;
   logic [TW-1:0] tgt;
   logic          hit;
   logic          allow, sel_rdy, acc, rsp;

   mem_noc_addr_dec #(
      .N_SLV    (N_SLV),
      .TW       (TW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_dec (
      .addr (mn_req.addr),
      .tgt  (tgt),
      .hit  (hit)
   );

   // Only one target may have requests in flight, which keeps responses in order.
   always_comb begin
      sel_rdy = 1'b0;
      for (int i = 0; i < N_SLV; i++)
         if (tgt == TW'(i)) sel_rdy = sn_req_ready[i];
      allow        = ((cnt == '0) || (tgt == cur_tgt)) && (cnt < CW'(MAX_OSTD));
      mn_req_ready = hit ? (allow && sel_rdy) : allow;
      for (int i = 0; i < N_SLV; i++) begin
         sn_req_valid[i] = mn_req_valid && allow && (tgt == TW'(i));
         sn_req[i]       = mn_req;
      end
   end

   always_comb begin
      mn_resp_valid = 1'b0;
      mn_resp       = '0;
      sn_resp_ready = '0;
      if (cnt != '0) begin
         if (cur_tgt == TW'(N_SLV)) begin
            mn_resp_valid = 1'b1;
            mn_resp.rdata = DERR_RDATA;
         end else begin
            for (int i = 0; i < N_SLV; i++) begin
               if (cur_tgt == TW'(i)) begin
                  mn_resp_valid    = sn_resp_valid[i];
                  mn_resp          = sn_resp[i];
                  sn_resp_ready[i] = mn_resp_ready;
               end
            end
         end
      end
   end

   assign acc        = mn_req_valid && mn_req_ready;
   assign rsp        = mn_resp_valid && mn_resp_ready;
   assign derr_pulse = acc && !hit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt     <= '0;
         cur_tgt <= '0;
      end else begin
         if (acc) cur_tgt <= tgt;
         if (acc && !rsp)      cnt <= cnt + CW'(1);
         else if (!acc && rsp) cnt <= cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_mem_noc_router_1ton.sv
// Directed bench for mem_noc_router_1ton: single read, burst, target switch, DERR, stray response, reset.
module tb_mem_noc_router_1ton;
   import mem_noc_router_1ton_pkg::*;

   localparam int N = 4;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 mn_req_valid, mn_req_ready;
   mem_req_t             mn_req;
   logic                 mn_resp_valid, mn_resp_ready;
   mem_resp_t            mn_resp;
   logic [N-1:0]         sn_req_valid, sn_req_ready;
   mem_req_t [N-1:0]     sn_req;
   logic [N-1:0]         sn_resp_valid, sn_resp_ready;
   mem_resp_t [N-1:0]    sn_resp;
   logic                 derr_pulse;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_noc_router_1ton dut (
      .clk           (clk),
      .rstn          (rstn),
      .mn_req_valid  (mn_req_valid),
      .mn_req_ready  (mn_req_ready),
      .mn_req        (mn_req),
      .mn_resp_valid (mn_resp_valid),
      .mn_resp_ready (mn_resp_ready),
      .mn_resp       (mn_resp),
      .sn_req_valid  (sn_req_valid),
      .sn_req_ready  (sn_req_ready),
      .sn_req        (sn_req),
      .sn_resp_valid (sn_resp_valid),
      .sn_resp_ready (sn_resp_ready),
      .sn_resp       (sn_resp),
      .derr_pulse    (derr_pulse)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive_req(input logic [31:0] a);
      mn_req_valid = 1'b1;
      mn_req       = '0;
      mn_req.addr  = a;
   endtask

   initial begin
      rstn          = 1'b0;
      mn_req_valid  = 1'b0;
      mn_req        = '0;
      mn_resp_ready = 1'b0;
      sn_req_ready  = '1;
      sn_resp_valid = '0;
      sn_resp       = '0;

      // Reset state
      repeat (2) smp();
      chk("rst_cnt", 32'(dut.cnt), 32'd0);
      chk("rst_curtgt", 32'(dut.cur_tgt), 32'd0);
      chk("rst_resp_valid", 32'(mn_resp_valid), 32'd0);
      chk("rst_sn_resp_ready", 32'(sn_resp_ready), 32'd0);
      chk("rst_derr", 32'(derr_pulse), 32'd0);
      step();
      rstn = 1'b1;
      step();

      // Single read to slave 0
      drive_req(32'h0200_0004);
      mn_req.wdata = 32'hCAFE_0001;
      smp();
      chk("t1_sn_req_valid", 32'(sn_req_valid), 32'b0001);
      chk("t1_req_ready", 32'(mn_req_ready), 32'd1);
      chk("t1_bcast_addr", sn_req[3].addr, 32'h0200_0004);
      chk("t1_bcast_wdata", sn_req[1].wdata, 32'hCAFE_0001);
      step();
      mn_req_valid = 1'b0;
      smp();
      chk("t1_cnt1", 32'(dut.cnt), 32'd1);
      chk("t1_resp_idle", 32'(mn_resp_valid), 32'd0);
      repeat (2) step();
      sn_resp_valid[0]    = 1'b1;
      sn_resp[0].rdata    = 32'h0000_1234;
      mn_resp_ready       = 1'b1;
      smp();
      chk("t1_resp_valid", 32'(mn_resp_valid), 32'd1);
      chk("t1_rdata", mn_resp.rdata, 32'h0000_1234);
      chk("t1_sn_resp_ready", 32'(sn_resp_ready), 32'b0001);
      step();
      sn_resp_valid = '0;
      mn_resp_ready = 1'b0;
      smp();
      chk("t1_cnt0", 32'(dut.cnt), 32'd0);

      // Pipelined burst to slave 2
      step();
      drive_req(32'h2000_0010);
      for (int k = 0; k < 4; k++) begin
         smp();
         chk($sformatf("t2_acc%0d", k), 32'(mn_req_ready), 32'd1);
         step();
      end
      smp();
      chk("t2_stall_ready", 32'(mn_req_ready), 32'd0);
      chk("t2_stall_valid", 32'(sn_req_valid), 32'd0);
      chk("t2_cnt4", 32'(dut.cnt), 32'd4);
      step();
      sn_resp_valid[2] = 1'b1;
      sn_resp[2].rdata = 32'h0000_00A0;
      mn_resp_ready    = 1'b1;
      smp();
      chk("t2_still_stall", 32'(mn_req_ready), 32'd0);
      chk("t2_rdata", mn_resp.rdata, 32'h0000_00A0);
      step();
      smp();
      chk("t2_cnt3", 32'(dut.cnt), 32'd3);
      chk("t2_ready_again", 32'(mn_req_ready), 32'd1);
      step();
      mn_req_valid = 1'b0;
      smp();
      chk("t2_cnt3_both", 32'(dut.cnt), 32'd3);
      repeat (3) step();
      sn_resp_valid = '0;
      mn_resp_ready = 1'b0;
      smp();
      chk("t2_drained", 32'(dut.cnt), 32'd0);

      // Target switch: slave 0 then slave 1
      step();
      drive_req(32'h0200_0000);
      step();
      drive_req(32'h0C00_0000);
      smp();
      chk("t3_blocked_valid", 32'(sn_req_valid), 32'd0);
      chk("t3_blocked_ready", 32'(mn_req_ready), 32'd0);
      step();
      sn_resp_valid[0] = 1'b1;
      sn_resp[0].rdata = 32'h0000_0055;
      mn_resp_ready    = 1'b1;
      smp();
      chk("t3_first_rdata", mn_resp.rdata, 32'h0000_0055);
      chk("t3_still_blocked", 32'(sn_req_valid), 32'd0);
      step();
      sn_resp_valid = '0;
      smp();
      chk("t3_switch_valid", 32'(sn_req_valid), 32'b0010);
      chk("t3_switch_ready", 32'(mn_req_ready), 32'd1);
      step();
      mn_req_valid     = 1'b0;
      sn_resp_valid[1] = 1'b1;
      sn_resp[1].rdata = 32'h0000_0066;
      smp();
      chk("t3_curtgt", 32'(dut.cur_tgt), 32'd1);
      chk("t3_second_rdata", mn_resp.rdata, 32'h0000_0066);
      chk("t3_sn_resp_ready", 32'(sn_resp_ready), 32'b0010);
      step();
      sn_resp_valid = '0;
      mn_resp_ready = 1'b0;
      smp();
      chk("t3_cnt0", 32'(dut.cnt), 32'd0);

      // Decode error
      step();
      drive_req(32'h8000_0000);
      smp();
      chk("t4_derr_pulse", 32'(derr_pulse), 32'd1);
      chk("t4_ready", 32'(mn_req_ready), 32'd1);
      chk("t4_no_slave", 32'(sn_req_valid), 32'd0);
      chk("t4_resp_not_yet", 32'(mn_resp_valid), 32'd0);
      step();
      mn_req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         smp();
         chk($sformatf("t4_pulse_low%0d", k), 32'(derr_pulse), 32'd0);
         chk($sformatf("t4_resp_valid%0d", k), 32'(mn_resp_valid), 32'd1);
         chk($sformatf("t4_rdata%0d", k), mn_resp.rdata, 32'hDEAD_BEEF);
         chk($sformatf("t4_err%0d", k), 32'(mn_resp.err), 32'd0);
         step();
      end
      mn_resp_ready = 1'b1;
      step();
      mn_resp_ready = 1'b0;
      smp();
      chk("t4_resp_done", 32'(mn_resp_valid), 32'd0);
      chk("t4_cnt0", 32'(dut.cnt), 32'd0);

      // Simultaneous accept+response at cnt=2, stray response on slave 3
      step();
      drive_req(32'h0200_0008);
      step();
      step();
      sn_resp_valid    = 4'b1001;
      sn_resp[0].rdata = 32'h0000_0077;
      mn_resp_ready    = 1'b1;
      smp();
      chk("t5_cnt2", 32'(dut.cnt), 32'd2);
      chk("t5_stray_ready", 32'(sn_resp_ready), 32'b0001);
      step();
      mn_req_valid = 1'b0;
      smp();
      chk("t5_cnt_held", 32'(dut.cnt), 32'd2);
      repeat (2) step();
      sn_resp_valid = '0;
      mn_resp_ready = 1'b0;
      smp();
      chk("t5_cnt0", 32'(dut.cnt), 32'd0);

      // Reset mid-operation
      step();
      drive_req(32'h0200_0000);
      repeat (3) step();
      mn_req_valid     = 1'b0;
      sn_resp_valid[0] = 1'b1;
      smp();
      chk("t6_cnt3", 32'(dut.cnt), 32'd3);
      chk("t6_resp_valid", 32'(mn_resp_valid), 32'd1);
      #1;
      rstn = 1'b0;
      #1;
      chk("t6_async_cnt", 32'(dut.cnt), 32'd0);
      chk("t6_async_resp", 32'(mn_resp_valid), 32'd0);
      sn_resp_valid = '0;
      step();
      rstn = 1'b1;
      step();
      drive_req(32'h3000_0100);
      smp();
      chk("t6_post_valid", 32'(sn_req_valid), 32'b1000);
      chk("t6_post_ready", 32'(mn_req_ready), 32'd1);
      step();
      mn_req_valid = 1'b0;
      smp();
      chk("t6_post_cnt", 32'(dut.cnt), 32'd1);
      chk("t6_post_curtgt", 32'(dut.cur_tgt), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
